// File: rtl/instr_queue.sv
`default_nettype none
// ============================================================================
//  Module      : instr_queue
//  Description : Instruction queue between instruction fetch and decode.
//                Buffers {instr, pc, next_pc} so fetch can run ahead of the
//                decoder. fetch_ready_o drops early enough to absorb SKID
//                in-flight fetch words. After a branch flush, the next
//                FLUSH_DROP cycles of fetch words are discarded as wrong-path.
//  Ports       : clk_i, rst_i            clock, synchronous active-high reset
//                fetch_*_i / fetch_ready_o  fetch-side push interface
//                flush_i                 branch redirect, empties the queue
//                dec_*_o / dec_ready_i   first-word-fall-through head to decoder
//                count_o                 occupied entries
//                overflow_o              one-cycle pulse when a push was lost
//  Revision    : 1.0  initial release
// ============================================================================
module instr_queue #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4,
    parameter int SKID       = 2,
    parameter int FLUSH_DROP = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       fetch_valid_i,
    input  logic [XLEN-1:0]            fetch_instr_i,
    input  logic [XLEN-1:0]            fetch_pc_i,
    input  logic [XLEN-1:0]            fetch_next_pc_i,
    output logic                       fetch_ready_o,
    input  logic                       flush_i,
    output logic                       dec_valid_o,
    output logic [XLEN-1:0]            dec_instr_o,
    output logic [XLEN-1:0]            dec_pc_o,
    output logic [XLEN-1:0]            dec_next_pc_o,
    input  logic                       dec_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam int c_DROP_W = (FLUSH_DROP > 0) ? $clog2(FLUSH_DROP + 1) : 1;

    localparam logic [c_CNT_W-1:0]  c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_SKID_CNT  = c_CNT_W'(SKID);
    localparam logic [c_DROP_W-1:0] c_DROP_LOAD = c_DROP_W'(FLUSH_DROP);

    // Elaboration-time parameter legality checks
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("instr_queue: DEPTH must be a power of two and >= 2");
    end
    if (SKID < 1 || SKID >= DEPTH) begin : g_chk_skid
        $error("instr_queue: SKID must satisfy 1 <= SKID < DEPTH");
    end
    if (FLUSH_DROP < 0) begin : g_chk_drop
        $error("instr_queue: FLUSH_DROP must be >= 0");
    end

    // Storage (not reset; validity is tracked by r_count)
    logic [XLEN-1:0]     r_instr   [DEPTH];
    logic [XLEN-1:0]     r_pc      [DEPTH];
    logic [XLEN-1:0]     r_next_pc [DEPTH];

    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_DROP_W-1:0] r_drop_cnt;
    logic                r_overflow;

    logic w_pop;
    logic w_push_req;
    logic w_push;

    assign dec_valid_o = (r_count != '0);
    assign w_pop       = dec_valid_o & dec_ready_i & ~flush_i;
    assign w_push_req  = fetch_valid_i & ~flush_i & (r_drop_cnt == '0);
    // A full queue can still take a word when the head leaves in the same cycle
    assign w_push      = w_push_req & ((r_count < c_DEPTH_CNT) | w_pop);

    // Ready means there is room for SKID more words already in the fetch pipe;
    // count never exceeds DEPTH so the subtraction cannot wrap.
    assign fetch_ready_o = ((c_DEPTH_CNT - r_count) >= c_SKID_CNT);

    assign dec_instr_o   = r_instr[r_rd_ptr];
    assign dec_pc_o      = r_pc[r_rd_ptr];
    assign dec_next_pc_o = r_next_pc[r_rd_ptr];
    assign count_o       = r_count;
    assign overflow_o    = r_overflow;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push_req & ~w_push;
            if (flush_i) begin
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_drop_cnt <= c_DROP_LOAD;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
                if (r_drop_cnt != '0) begin
                    r_drop_cnt <= r_drop_cnt - c_DROP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !rst_i) begin
            r_instr[r_wr_ptr]   <= fetch_instr_i;
            r_pc[r_wr_ptr]      <= fetch_pc_i;
            r_next_pc[r_wr_ptr] <= fetch_next_pc_i;
        end
    end

endmodule
`default_nettype wire
